ula_acumulador: RTL and testbench
=================================

Name: ula_acumulador

Overview:
Sequential controller that sits directly upstream and downstream of the 4-bit ULA (AND/OR/NOT/NAND/ADD/SUB/LSL/LSR). It accepts operation commands over a valid/ready handshake and drives the ULA operand and selector ports from an internal accumulator register. After a programmable settle time it captures the ULA result back into the accumulator. It then returns the new accumulator value and status flags over a second valid/ready handshake. Turns the combinational ULA into a register-based accumulator datapath.

Parameters:
WIDTH, 4, datapath width of accumulator, operand and ULA ports
EXEC_CYCLES, 1, cycles the ULA inputs are held stable before the result is captured (≥1)

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command
cmd_load  input  1  1 = load accumulator with cmd_b, bypassing the ULA
cmd_op  input  3  ULA selector code (ignored when cmd_load=1)
cmd_b  input  WIDTH  operand B, or load value
ula_a  output  WIDTH  to ULA A; registered copy of accumulator
ula_b  output  WIDTH  to ULA B; registered cmd_b
ula_sel  output  3  to ULA seletor; registered cmd_op
ula_res  input  WIDTH  from ULA resultado
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_acc  output  WIDTH  accumulator value
rsp_zero  output  1  rsp_acc == 0
rsp_neg  output  1  rsp_acc[WIDTH-1]

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is asynchronous and active-high, as already decided.
- Reset values: acc=0, ula_a/ula_b/ula_sel=0, rsp_valid=0, state=IDLE, wait counter=0. cmd_ready=0 while rst is high.
- FSM states: IDLE, EXEC, RESP. Encoding is 2 bits.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready with cmd_load=1: acc←cmd_b, next state RESP.
  - On cmd_valid&&cmd_ready with cmd_load=0: ula_a←acc, ula_b←cmd_b, ula_sel←cmd_op, counter←EXEC_CYCLES-1, next state EXEC.
- EXEC:
  - cmd_ready=0. ula_* outputs are held constant.
  - Counter decrements each cycle.
  - In the cycle where counter==0: acc←ula_res, next state RESP.
  - Latency from handshake edge to rsp_valid is EXEC_CYCLES+1 cycles for ops. For loads it is 1 cycle.
- RESP:
  - rsp_valid=1. rsp_acc, rsp_zero and rsp_neg are stable while rsp_valid && !rsp_ready.
  - On rsp_ready: next state IDLE, rsp_valid=0.
  - No command is accepted in the same cycle as the response handshake. Maximum throughput is one command per EXEC_CYCLES+2 cycles.
- Arithmetic is done by the ULA, modulo 2^WIDTH. Wrap-around is never an error.
- rsp_zero and rsp_neg are combinational from acc.
- cmd_op is passed through unchanged. All 8 codes are legal.
- Reset asserted mid-EXEC or mid-RESP aborts the operation immediately. The accumulator returns to 0 and no response is produced.
- cmd_valid while cmd_ready=0 is ignored. The upstream must hold the command.

Optional Feature:
Macro: ULA_ACUMULADOR_CARRY_EN.
- Defined:
  - Adds output port rsp_carry (1 bit, reset 0), captured at the same edge as acc.
  - For op 100 (ADD), rsp_carry is the bit WIDTH of acc+cmd_b.
  - For op 101 (SUB), rsp_carry is the borrow, i.e. acc<cmd_b unsigned.
  - For all other ops and for loads, rsp_carry=0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package ula_pkg holds:
  - Op-code constants OP_AND=000, OP_OR=001, OP_NOT=010, OP_NAND=011, OP_ADD=100, OP_SUB=101, OP_LSL=110, OP_LSR=111.
  - FSM state constants S_IDLE, S_EXEC, S_RESP.
- No sub-module. The ULA stays external and is connected by the integrating top level. The test bench instantiates both blocks.

Test Plan:
- Load and add: load B=0101, then op ADD B=0011 with rsp_ready=1 → rsp_acc=1000, zero=0, neg=1. rsp_valid rises 2 cycles after the ADD handshake (EXEC_CYCLES=1).
- Subtract wrap: acc=1000, op SUB B=1001 → rsp_acc=1111, neg=1. With CARRY_EN, rsp_carry=1.
- Shifts: load 1001, op LSL → 0010; load 1001, op LSR → 0100.
- Zero flag and carry: load 1101, op AND B=0010 → rsp_acc=0000, zero=1. Load 1101, op ADD B=1010 → 0111; with CARRY_EN, rsp_carry=1.
- Backpressure: hold rsp_ready=0 for 5 cycles → rsp_valid and rsp_acc stable, cmd_ready=0 throughout, and a cmd_valid pulse is ignored. Release → IDLE on the next cycle.
- Reset mid-operation: EXEC_CYCLES=3, assert rst asynchronously during EXEC → immediately acc=0, rsp_valid=0, ula_*=0. After release cmd_ready=1 and a new load succeeds.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared op-codes and FSM states for the ULA accumulator controller.
package ula_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NOT  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_LSL  = 3'b110;
  localparam logic [2:0] OP_LSR  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/ula_acumulador.sv
// Accumulator controller wrapped around an external combinational ULA.
// Optional carry/borrow output enabled with macro ULA_ACUMULADOR_CARRY_EN.
module ula_acumulador
  import ula_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] ula_a,
  output logic [WIDTH-1:0] ula_b,
  output logic [2:0]       ula_sel,
  input  logic [WIDTH-1:0] ula_res,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_acc,
  output logic             rsp_zero,
  output logic             rsp_neg
`ifdef ULA_ACUMULADOR_CARRY_EN
  ,
  output logic             rsp_carry
`endif
);

  localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(EXEC_CYCLES - 1);

  state_t             state_r;
  state_t             state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   acc_r;
  logic [WIDTH-1:0]   ula_a_r;
  logic [WIDTH-1:0]   ula_b_r;
  logic [2:0]         ula_sel_r;
  logic               cmd_fire_s;
  logic               cnt_done_s;

  // Ready is forced low while reset is held, even though state already reads IDLE.
  assign cmd_ready  = (state_r == S_IDLE) && !rst;
  assign cmd_fire_s = cmd_valid && cmd_ready;
  assign cnt_done_s = (cnt_r == {CNT_W{1'b0}});

  assign ula_a     = ula_a_r;
  assign ula_b     = ula_b_r;
  assign ula_sel   = ula_sel_r;
  assign rsp_valid = (state_r == S_RESP);
  assign rsp_acc   = acc_r;
  assign rsp_zero  = (acc_r == {WIDTH{1'b0}});
  assign rsp_neg   = acc_r[WIDTH-1];

`ifdef ULA_ACUMULADOR_CARRY_EN
  logic carry_r;
  logic carry_s;

  // Carry out of A+B for ADD, unsigned borrow for SUB, zero otherwise.
  function automatic logic carry_of(input logic [2:0] op,
                                    input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b);
    case (op)
      OP_ADD:  carry_of = (({1'b0, a} + {1'b0, b}) > {1'b0, {WIDTH{1'b1}}});
      OP_SUB:  carry_of = (a < b);
      default: carry_of = 1'b0;
    endcase
  endfunction

  // Carry evaluated from the held ULA operands so it lines up with ula_res.
  always_comb begin
    carry_s = carry_of(ula_sel_r, ula_a_r, ula_b_r);
  end

  assign rsp_carry = carry_r;

  // Carry register, captured on the same edge as the accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE:  if (cmd_fire_s && cmd_load) carry_r <= 1'b0;
        S_EXEC:  if (cnt_done_s) carry_r <= carry_s;
        default: carry_r <= carry_r;
      endcase
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (cmd_fire_s) begin
          state_s = cmd_load ? S_RESP : S_EXEC;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_EXEC: begin
        if (cnt_done_s) begin
          state_s = S_RESP;
        end else begin
          state_s = S_EXEC;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_RESP;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Datapath: operand launch on accept, result capture when the settle counter expires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r     <= {WIDTH{1'b0}};
      ula_a_r   <= {WIDTH{1'b0}};
      ula_b_r   <= {WIDTH{1'b0}};
      ula_sel_r <= 3'b000;
      cnt_r     <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (cmd_fire_s) begin
            if (cmd_load) begin
              acc_r <= cmd_b;
            end else begin
              ula_a_r   <= acc_r;
              ula_b_r   <= cmd_b;
              ula_sel_r <= cmd_op;
              cnt_r     <= CNT_INIT;
            end
          end
        end
        S_EXEC: begin
          if (cnt_done_s) begin
            acc_r <= ula_res;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_acumulador.sv
// Directed bench: two controllers (EXEC_CYCLES=1 and 3), each closed around a ULA stand-in.
module tb_ula_acumulador;
  import ula_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst3, v1, v3, r1, r3;
  logic cmd_load;
  logic [2:0] cmd_op;
  logic [W-1:0] cmd_b;

  logic d1_ready, d1_valid, d1_zero, d1_neg, d1_carry;
  logic [W-1:0] d1_ula_a, d1_ula_b, d1_ula_res, d1_acc;
  logic [2:0] d1_ula_sel;
  logic d3_ready, d3_valid, d3_zero, d3_neg, d3_carry;
  logic [W-1:0] d3_ula_a, d3_ula_b, d3_ula_res, d3_acc;
  logic [2:0] d3_ula_sel;

  int n_cmp = 0;
  int n_err = 0;
  logic tgt3;

  function automatic logic [W-1:0] ula_f(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
    case (s)
      3'b000:  ula_f = a & b;
      3'b001:  ula_f = a | b;
      3'b010:  ula_f = ~a;
      3'b011:  ula_f = ~(a & b);
      3'b100:  ula_f = a + b;
      3'b101:  ula_f = a - b;
      3'b110:  ula_f = a << 1;
      default: ula_f = a >> 1;
    endcase
  endfunction

  assign d1_ula_res = ula_f(d1_ula_sel, d1_ula_a, d1_ula_b);
  assign d3_ula_res = ula_f(d3_ula_sel, d3_ula_a, d3_ula_b);

`ifndef ULA_ACUMULADOR_CARRY_EN
  assign d1_carry = 1'b0;
  assign d3_carry = 1'b0;
`endif

  ula_acumulador #(.WIDTH(W), .EXEC_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst1), .cmd_valid(v1), .cmd_ready(d1_ready), .cmd_load(cmd_load),
    .cmd_op(cmd_op), .cmd_b(cmd_b), .ula_a(d1_ula_a), .ula_b(d1_ula_b), .ula_sel(d1_ula_sel),
    .ula_res(d1_ula_res), .rsp_valid(d1_valid), .rsp_ready(r1), .rsp_acc(d1_acc),
    .rsp_zero(d1_zero), .rsp_neg(d1_neg)
`ifdef ULA_ACUMULADOR_CARRY_EN
    , .rsp_carry(d1_carry)
`endif
  );

  ula_acumulador #(.WIDTH(W), .EXEC_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst3), .cmd_valid(v3), .cmd_ready(d3_ready), .cmd_load(cmd_load),
    .cmd_op(cmd_op), .cmd_b(cmd_b), .ula_a(d3_ula_a), .ula_b(d3_ula_b), .ula_sel(d3_ula_sel),
    .ula_res(d3_ula_res), .rsp_valid(d3_valid), .rsp_ready(r3), .rsp_acc(d3_acc),
    .rsp_zero(d3_zero), .rsp_neg(d3_neg)
`ifdef ULA_ACUMULADOR_CARRY_EN
    , .rsp_carry(d3_carry)
`endif
  );

  logic m_ready, m_valid, m_zero, m_neg, m_carry;
  logic [W-1:0] m_acc;
  assign m_ready = tgt3 ? d3_ready : d1_ready;
  assign m_valid = tgt3 ? d3_valid : d1_valid;
  assign m_zero  = tgt3 ? d3_zero  : d1_zero;
  assign m_neg   = tgt3 ? d3_neg   : d1_neg;
  assign m_carry = tgt3 ? d3_carry : d1_carry;
  assign m_acc   = tgt3 ? d3_acc   : d1_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_valid(input logic val);
    if (tgt3) v3 = val; else v1 = val;
  endtask

  task automatic set_ready(input logic val);
    if (tgt3) r3 = val; else r1 = val;
  endtask

  // Present a command for exactly one edge; caller sits at posedge+1 in IDLE.
  task automatic do_cmd(input string tag, input logic load, input logic [2:0] op, input logic [W-1:0] b);
    cmd_load = load; cmd_op = op; cmd_b = b;
    set_valid(1'b1);
    chk({tag, "_cmd_ready"}, m_ready, 1);
    @(posedge clk); #1;
    set_valid(1'b0);
  endtask

  task automatic run_op(input string tag, input logic load, input logic [2:0] op, input logic [W-1:0] b,
                        input int exp_lat, input logic [W-1:0] exp_acc, input logic exp_zero,
                        input logic exp_neg, input logic exp_carry, input bit consume);
    int lat;
    do_cmd(tag, load, op, b);
    lat = 1;
    while (!m_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_acc"}, m_acc, exp_acc);
    chk({tag, "_zero"}, m_zero, exp_zero);
    chk({tag, "_neg"}, m_neg, exp_neg);
`ifdef ULA_ACUMULADOR_CARRY_EN
    chk({tag, "_carry"}, m_carry, exp_carry);
`else
    if (exp_carry === 1'bx) chk({tag, "_carry_x"}, m_carry, 0);
`endif
    if (consume) begin
      set_ready(1'b1);
      @(posedge clk); #1;
      set_ready(1'b0);
      chk({tag, "_valid_drop"}, m_valid, 0);
      chk({tag, "_ready_back"}, m_ready, 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst1 = 1'b1; rst3 = 1'b1; v1 = 1'b0; v3 = 1'b0; r1 = 1'b0; r3 = 1'b0;
    cmd_load = 1'b0; cmd_op = 3'b000; cmd_b = 4'b0000; tgt3 = 1'b0;
    #2;
    chk("rst_cmd_ready", d1_ready, 0);
    chk("rst_rsp_valid", d1_valid, 0);
    chk("rst_acc", d1_acc, 0);
    chk("rst_ula_a", d1_ula_a, 0);
    chk("rst_ula_sel", d1_ula_sel, 0);
    chk("rst_zero", d1_zero, 1);
    chk("rst3_cmd_ready", d3_ready, 0);
    #20;
    rst1 = 1'b0; rst3 = 1'b0;
    #1;
    chk("post_rst_ready", d1_ready, 1);
    @(posedge clk); #1;

    run_op("load5",   1'b1, OP_AND, 4'b0101, 1, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op("add3",    1'b0, OP_ADD, 4'b0011, 2, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("add3_ula_a", d1_ula_a, 4'b0101);
    chk("add3_ula_b", d1_ula_b, 4'b0011);
    chk("add3_ula_sel", d1_ula_sel, 3'b100);
    run_op("sub9",    1'b0, OP_SUB, 4'b1001, 2, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b1);
    run_op("load9a",  1'b1, OP_ADD, 4'b1001, 1, 4'b1001, 1'b0, 1'b1, 1'b0, 1'b1);
    run_op("lsl",     1'b0, OP_LSL, 4'b0000, 2, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op("load9b",  1'b1, OP_AND, 4'b1001, 1, 4'b1001, 1'b0, 1'b1, 1'b0, 1'b1);
    run_op("lsr",     1'b0, OP_LSR, 4'b0000, 2, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op("load13a", 1'b1, OP_AND, 4'b1101, 1, 4'b1101, 1'b0, 1'b1, 1'b0, 1'b1);
    run_op("and2",    1'b0, OP_AND, 4'b0010, 2, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
    run_op("load13b", 1'b1, OP_AND, 4'b1101, 1, 4'b1101, 1'b0, 1'b1, 1'b0, 1'b1);
    run_op("add10",   1'b0, OP_ADD, 4'b1010, 2, 4'b0111, 1'b0, 1'b0, 1'b1, 1'b0);

    // Backpressure with a stray command pulse that must be ignored.
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", d1_valid, 1);
      chk("bp_acc", d1_acc, 4'b0111);
      chk("bp_cmd_ready", d1_ready, 0);
      if (i == 1) begin
        cmd_load = 1'b1; cmd_b = 4'b0000; v1 = 1'b1;
      end else begin
        v1 = 1'b0;
      end
      @(posedge clk); #1;
    end
    v1 = 1'b0;
    r1 = 1'b1;
    @(posedge clk); #1;
    r1 = 1'b0;
    chk("bp_release_valid", d1_valid, 0);
    chk("bp_release_ready", d1_ready, 1);
    chk("bp_acc_kept", d1_acc, 4'b0111);
    run_op("not",     1'b0, OP_NOT, 4'b0000, 2, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1);

    // Reset in the middle of a 3-cycle execution.
    tgt3 = 1'b1;
    run_op("d3_load5", 1'b1, OP_AND, 4'b0101, 1, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b1);
    do_cmd("d3_add", 1'b0, OP_ADD, 4'b0011);
    chk("d3_exec_ula_a", d3_ula_a, 4'b0101);
    chk("d3_exec_ready", d3_ready, 0);
    #2;
    rst3 = 1'b1;
    #1;
    chk("d3_rst_acc", d3_acc, 0);
    chk("d3_rst_valid", d3_valid, 0);
    chk("d3_rst_ula_a", d3_ula_a, 0);
    chk("d3_rst_ula_b", d3_ula_b, 0);
    chk("d3_rst_ula_sel", d3_ula_sel, 0);
    chk("d3_rst_ready", d3_ready, 0);
    @(posedge clk); @(posedge clk);
    #3;
    rst3 = 1'b0;
    #1;
    chk("d3_post_rst_ready", d3_ready, 1);
    chk("d3_post_rst_valid", d3_valid, 0);
    @(posedge clk); #1;
    chk("d3_no_late_rsp", d3_valid, 0);
    run_op("d3_load6", 1'b1, OP_AND, 4'b0110, 1, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op("d3_or9",   1'b0, OP_OR,  4'b1001, 4, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
